// File: rtl/vga_frame_scheduler.sv
// Shares one VGA output between NUM_SRC pixel sources, handing ownership over only at
// frame boundaries (round-robin with a minimum hold) and driving a 2-stage blanked RGB mux.
module vga_frame_scheduler #(
    parameter int unsigned VIDEO_WIDTH = 3,
    parameter int unsigned TOTAL_COLS  = 800,
    parameter int unsigned TOTAL_ROWS  = 525,
    parameter int unsigned ACTIVE_COLS = 640,
    parameter int unsigned ACTIVE_ROWS = 480,
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned HOLD_FRAMES = 2
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           ihsync,
    input  logic                           ivsync,
    input  logic [NUM_SRC-1:0]             req,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] iredv,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] igrnv,
    input  logic [NUM_SRC*VIDEO_WIDTH-1:0] ibluv,
    output logic [NUM_SRC-1:0]             grant,
    output logic                           frame_start,
    output logic                           hsync,
    output logic                           vsync,
    output logic [VIDEO_WIDTH-1:0]         oredv,
    output logic [VIDEO_WIDTH-1:0]         ogrnv,
    output logic [VIDEO_WIDTH-1:0]         obluv
);
    localparam int unsigned ColW  = $clog2(TOTAL_COLS);
    localparam int unsigned RowW  = $clog2(TOTAL_ROWS);
    localparam int unsigned IdxW  = $clog2(NUM_SRC);
    localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);

    localparam logic [ColW-1:0]    ColLast  = ColW'(TOTAL_COLS - 1);
    localparam logic [ColW-1:0]    ActCols  = ColW'(ACTIVE_COLS);
    localparam logic [RowW-1:0]    RowLast  = RowW'(TOTAL_ROWS - 1);
    localparam logic [RowW-1:0]    ActRows  = RowW'(ACTIVE_ROWS);
    localparam logic [RowW-1:0]    TickRow  = RowW'(ACTIVE_ROWS - 1);
    localparam logic [IdxW-1:0]    IdxLast  = IdxW'(NUM_SRC - 1);
    localparam logic [HoldW-1:0]   HoldSat  = HoldW'(HOLD_FRAMES);
    localparam logic [HoldW-1:0]   HoldLast = HoldW'(HOLD_FRAMES - 1);
    localparam logic [NUM_SRC-1:0] OneHot0  = NUM_SRC'(1);

    typedef enum logic [1:0] {StIdle, StOwned, StPending} state_e;

    state_e                 state_q;
    logic [NUM_SRC-1:0]     grant_q;
    logic [IdxW-1:0]        owner_q, rr_ptr_q, owner_inc;
    logic [HoldW-1:0]       hold_q;
    logic [ColW-1:0]        col_q;
    logic [RowW-1:0]        row_q;
    logic                   locked_q, frame_start_q;
    logic                   hs1_q, vs1_q, hs2_q, vs2_q, blank1_q;
    logic [VIDEO_WIDTH-1:0] r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
    logic [VIDEO_WIDTH-1:0] r_sel, g_sel, b_sel;
    logic                   vs_rise, tick, owner_req, others_req, blank_d;
    logic                   nxt_found, rr_found;
    logic [IdxW-1:0]        nxt_idx, rr_idx;

    // vs1_q doubles as the edge-detect history and the first sync pipeline stage.
    assign vs_rise    = ivsync & ~vs1_q;
    assign tick       = locked_q & ~vs_rise & (col_q == ColLast) & (row_q == TickRow);
    assign owner_req  = |(req & grant_q);
    assign others_req = |(req & ~grant_q);
    assign owner_inc  = (owner_q == IdxLast) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            col_q         <= '0;
            row_q         <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= vs_rise;
            if (vs_rise) begin
                col_q    <= '0;
                row_q    <= '0;
                locked_q <= 1'b1;
            end else if (col_q == ColLast) begin
                col_q <= '0;
                row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // rr_idx: first requester at or after rr_ptr; nxt_idx: first requester after the owner,
    // where offset NUM_SRC wraps back onto the owner itself.
    always_comb begin
        int unsigned i;
        nxt_found = 1'b0;
        nxt_idx   = owner_q;
        rr_found  = 1'b0;
        rr_idx    = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            i = (32'(rr_ptr_q) + k) % NUM_SRC;
            if (!rr_found && req[IdxW'(i)]) begin
                rr_found = 1'b1;
                rr_idx   = IdxW'(i);
            end
            i = (32'(owner_q) + k + 1) % NUM_SRC;
            if (!nxt_found && req[IdxW'(i)]) begin
                nxt_found = 1'b1;
                nxt_idx   = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tick && rr_found) begin
                        state_q <= StOwned;
                        owner_q <= rr_idx;
                        grant_q <= OneHot0 << rr_idx;
                        hold_q  <= '0;
                    end
                end
                StOwned, StPending: begin
                    if (tick) begin
                        if (!owner_req || (state_q == StPending && hold_q >= HoldLast
                                           && nxt_found && nxt_idx != owner_q)) begin
                            rr_ptr_q <= owner_inc;
                            hold_q   <= '0;
                            if (nxt_found && nxt_idx != owner_q) begin
                                state_q <= StOwned;
                                owner_q <= nxt_idx;
                                grant_q <= OneHot0 << nxt_idx;
                            end else begin
                                state_q <= StIdle;
                                grant_q <= '0;
                            end
                        end else begin
                            hold_q  <= (hold_q == HoldSat) ? hold_q : hold_q + 1'b1;
                            state_q <= others_req ? StPending : StOwned;
                        end
                    end else if (others_req) begin
                        state_q <= StPending;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // One-hot AND-OR select; an all-zero grant yields black.
    always_comb begin
        r_sel = '0;
        g_sel = '0;
        b_sel = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (grant_q[s]) begin
                r_sel = r_sel | iredv[s*VIDEO_WIDTH +: VIDEO_WIDTH];
                g_sel = g_sel | igrnv[s*VIDEO_WIDTH +: VIDEO_WIDTH];
                b_sel = b_sel | ibluv[s*VIDEO_WIDTH +: VIDEO_WIDTH];
            end
        end
    end

    assign blank_d = (col_q >= ActCols) | (row_q >= ActRows) | (state_q == StIdle) | ~locked_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            blank1_q <= 1'b1;
            r1_q     <= '0;
            g1_q     <= '0;
            b1_q     <= '0;
            r2_q     <= '0;
            g2_q     <= '0;
            b2_q     <= '0;
        end else begin
            hs1_q    <= ihsync;
            vs1_q    <= ivsync;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            blank1_q <= blank_d;
            r1_q     <= r_sel;
            g1_q     <= g_sel;
            b1_q     <= b_sel;
            r2_q     <= blank1_q ? '0 : r1_q;
            g2_q     <= blank1_q ? '0 : g1_q;
            b2_q     <= blank1_q ? '0 : b1_q;
        end
    end

    assign grant       = grant_q;
    assign frame_start = frame_start_q;
    assign hsync       = hs2_q;
    assign vsync       = vs2_q;
    assign oredv       = r2_q;
    assign ogrnv       = g2_q;
    assign obluv       = b2_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler on a shrunken 10x8 raster (6x5 visible).
module tb_vga_frame_scheduler;
    localparam int unsigned Tc = 10;
    localparam int unsigned Tr = 8;
    localparam logic [8:0] Pix0 = {3'd5, 3'd1, 3'd3};
    localparam logic [8:0] Pix1 = {3'd2, 3'd6, 3'd1};
    localparam logic [8:0] Pix2 = {3'd3, 3'd4, 3'd7};

    logic        clock = 1'b0;
    logic        resetn;
    logic        ihsync, ivsync;
    logic [3:0]  req;
    logic [11:0] iredv, igrnv, ibluv;
    logic [3:0]  grant;
    logic        frame_start, hsync, vsync;
    logic [2:0]  oredv, ogrnv, obluv;
    logic [8:0]  rgb;

    int unsigned g_row, g_col;
    int          n_checks = 0;
    int          n_errors = 0;

    assign rgb = {oredv, ogrnv, obluv};

    always #5 clock = ~clock;

    vga_frame_scheduler #(
        .VIDEO_WIDTH(3),
        .TOTAL_COLS (Tc),
        .TOTAL_ROWS (Tr),
        .ACTIVE_COLS(6),
        .ACTIVE_ROWS(5),
        .NUM_SRC    (4),
        .HOLD_FRAMES(2)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ihsync     (ihsync),
        .ivsync     (ivsync),
        .req        (req),
        .iredv      (iredv),
        .igrnv      (igrnv),
        .ibluv      (ibluv),
        .grant      (grant),
        .frame_start(frame_start),
        .hsync      (hsync),
        .vsync      (vsync),
        .oredv      (oredv),
        .ogrnv      (ogrnv),
        .obluv      (obluv)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_syncs();
        ihsync = (g_col < 7);
        ivsync = (g_row == 0) && (g_col < 3);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        if (g_col == Tc - 1) begin
            g_col = 0;
            g_row = (g_row == Tr - 1) ? 0 : g_row + 1;
        end else begin
            g_col = g_col + 1;
        end
        drive_syncs();
    endtask

    // Advance to the next occurrence of the generator position (r, c).
    task automatic wait_pos(input int unsigned r, input int unsigned c);
        int unsigned n = 0;
        do begin
            next_cycle();
            n++;
        end while (!(g_row == r && g_col == c) && n <= Tc * Tr);
        if (!(g_row == r && g_col == c))
            check_val("reach_pos", (g_row << 8) | g_col, (r << 8) | c);
    endtask

    logic [3:0] exp_rr [9] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001,
                               4'b0001, 4'b0010, 4'b0010, 4'b0100};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        req    = 4'b0000;
        iredv  = {3'd4, 3'd3, 3'd2, 3'd5};
        igrnv  = {3'd7, 3'd4, 3'd6, 3'd1};
        ibluv  = {3'd2, 3'd7, 3'd1, 3'd3};
        g_row  = 3;
        g_col  = 0;
        drive_syncs();

        repeat (5) next_cycle();
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_hsync", 32'(hsync), 32'h1);
        check_val("rst_vsync", 32'(vsync), 32'h1);
        check_val("rst_rgb", 32'(rgb), 32'h0);
        check_val("rst_fstart", 32'(frame_start), 32'h0);
        resetn = 1'b1;
        req    = 4'b0001;

        wait_pos(6, 0);
        check_val("unlocked_grant", 32'(grant), 32'h0);
        wait_pos(0, 1);
        check_val("fstart_pulse", 32'(frame_start), 32'h1);
        check_val("vsync_lat_lo", 32'(vsync), 32'h0);
        wait_pos(0, 2);
        check_val("fstart_one_cycle", 32'(frame_start), 32'h0);
        check_val("vsync_lat_hi", 32'(vsync), 32'h1);
        wait_pos(5, 0);
        check_val("tick1_before", 32'(grant), 32'h0);
        wait_pos(5, 1);
        check_val("tick1_grant", 32'(grant), 32'h1);

        wait_pos(1, 2);
        check_val("hblank_left", 32'(rgb), 32'h0);
        wait_pos(1, 3);
        check_val("pix_first", 32'(rgb), 32'(Pix0));
        wait_pos(1, 8);
        check_val("pix_last", 32'(rgb), 32'(Pix0));
        check_val("hsync_lat_hi", 32'(hsync), 32'h1);
        wait_pos(1, 9);
        check_val("hblank_right", 32'(rgb), 32'h0);
        check_val("hsync_lat_lo", 32'(hsync), 32'h0);
        req = 4'b0011;
        wait_pos(4, 5);
        check_val("pix_last_row", 32'(rgb), 32'(Pix0));
        wait_pos(5, 1);
        check_val("hold_tick2", 32'(grant), 32'h1);
        wait_pos(5, 5);
        check_val("vblank", 32'(rgb), 32'h0);
        wait_pos(5, 1);
        check_val("hold_tick3", 32'(grant), 32'h2);

        wait_pos(2, 4);
        check_val("pix_src1", 32'(rgb), 32'(Pix1));
        req = 4'b1111;
        wait_pos(5, 1);
        check_val("rr_tick4", 32'(grant), 32'h2);
        for (int f = 0; f < 9; f++) begin
            wait_pos(5, 1);
            check_val($sformatf("rr_tick%0d", f + 5), 32'(grant), 32'(exp_rr[f]));
        end

        wait_pos(2, 5);
        req = 4'b0001;
        wait_pos(3, 0);
        check_val("rel_midframe", 32'(grant), 32'h4);
        wait_pos(3, 4);
        check_val("rel_pix_a", 32'(rgb), 32'(Pix2));
        wait_pos(4, 8);
        check_val("rel_pix_b", 32'(rgb), 32'(Pix2));
        wait_pos(5, 0);
        check_val("rel_before_tick", 32'(grant), 32'h4);
        wait_pos(5, 1);
        check_val("rel_after_tick", 32'(grant), 32'h1);

        wait_pos(1, 3);
        check_val("rel_pix_src0", 32'(rgb), 32'(Pix0));
        wait_pos(2, 3);
        resetn = 1'b0;
        wait_pos(2, 4);
        check_val("mid_rst_grant", 32'(grant), 32'h0);
        check_val("mid_rst_hsync", 32'(hsync), 32'h1);
        check_val("mid_rst_vsync", 32'(vsync), 32'h1);
        check_val("mid_rst_rgb", 32'(rgb), 32'h0);
        check_val("mid_rst_fstart", 32'(frame_start), 32'h0);
        resetn = 1'b1;
        wait_pos(5, 1);
        check_val("relock_no_tick", 32'(grant), 32'h0);
        wait_pos(0, 1);
        check_val("relock_fstart", 32'(frame_start), 32'h1);
        wait_pos(5, 1);
        check_val("relock_grant", 32'(grant), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

Shares one VGA output between up to NUM_SRC pixel sources, granting ownership in whole frames. Sits between the sync generator / pattern sources and the porch stage. Tracks the frame position from the incoming syncs, arbitrates round-robin at each frame boundary with a minimum hold, and drives a pipelined, blanked RGB mux with sync delayed to match.

## Interface
- VIDEO_WIDTH, 3, bits per colour channel
- TOTAL_COLS, 800, columns per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible lines
- NUM_SRC, 4, number of requesters (2..8)
- HOLD_FRAMES, 2, minimum frames an owner keeps the grant against competing requests (≥1)

- clock  in  1  sole clock, all logic on posedge
- resetn  in  1  synchronous, active-low reset
- ihsync  in  1  horizontal sync from generator
- ivsync  in  1  vertical sync from generator
- req  in  NUM_SRC  level request per source
- iredv  in  NUM_SRC*VIDEO_WIDTH  packed red, source i at [i*VIDEO_WIDTH +: VIDEO_WIDTH]
- igrnv  in  NUM_SRC*VIDEO_WIDTH  packed green, same packing
- ibluv  in  NUM_SRC*VIDEO_WIDTH  packed blue, same packing
- grant  out  NUM_SRC  one-hot current owner, all-zero when idle
- frame_start  out  1  one-cycle pulse at each detected frame start
- hsync  out  1  ihsync delayed 2 cycles
- vsync  out  1  ivsync delayed 2 cycles
- oredv, ogrnv, obluv  out  VIDEO_WIDTH each  selected, blanked pixel

## Operation
- Position tracking: ivsync registered; rising edge (0→1) = frame start: col←0, row←0, frame_start pulses, locked←1. Otherwise col increments; col==TOTAL_COLS-1 wraps to 0 and increments row; row==TOTAL_ROWS-1 with col wrap wraps row to 0.
- Boundary tick: col==TOTAL_COLS-1 and row==ACTIVE_ROWS-1 and locked (last visible pixel). All grant changes occur only on this tick. No ticks before locked.
- FSM states: IDLE, OWNED, PENDING.
  - IDLE: grant=0. At tick, if any req: grant first requester at or after rr_ptr (round-robin), hold_cnt←0, →OWNED.
  - OWNED: at tick hold_cnt increments (saturating at HOLD_FRAMES). If another source requests →PENDING (the decision still happens at a tick).
  - PENDING: at tick, if owner's req low → release; else if hold_cnt+1 ≥ HOLD_FRAMES → hand over to next requester after owner in round-robin order; else stay.
  - Owner's req low at a tick in any owned state: grant passes to next requester after owner, or IDLE if none. Owner never revoked mid-frame.
  - On every handover rr_ptr←owner+1 (mod NUM_SRC); hold_cnt←0.
  - Sole requester keeps grant indefinitely.
- Datapath stage 1: register the granted source's RGB (zero if idle), blank flag = (col≥ACTIVE_COLS)|(row≥ACTIVE_ROWS)|idle|!locked, syncs. Stage 2: RGB = blank ? 0 : stage-1 RGB; syncs registered again.
- Grant change at tick affects pixels from the next cycle; all such pixels are in vertical blanking, so no frame ever mixes sources.

## Timing
- Reset (resetn low at a posedge): grant=0, frame_start=0, hsync=1, vsync=1, RGB=0, col=row=0, locked=0, rr_ptr=0, hold_cnt=0, state IDLE. Pipeline registers cleared to the same values. Reset mid-frame drops ownership immediately; relock needed.
- Sync and pixel latency: exactly 2 cycles from input to output, identical for hsync, vsync, RGB.
- frame_start: asserts the cycle after ivsync is sampled 1 following a 0.
- grant updates on the posedge after the tick cycle.
- Simultaneous frame start and tick (degenerate parameters) – frame start wins, tick skipped.
- req changes between ticks are ignored except via the state machine's registered PENDING flag.

## Test plan
- Reset: hold resetn low 5 cycles with syncs toggling -> grant=0, hsync=vsync=1, RGB=0; after release, no grant until first ivsync rise.
- Single requester: req=0001 after lock -> grant=0001 at first tick; source 0 pixel 3'b101 shown at active pixels, 0 at col≥640 and row≥480, 2-cycle latency.
- Hold: req=0011, owner 0, HOLD_FRAMES=2 -> grant stays 0001 for 2 frames, becomes 0010 at 2nd tick.
- Round-robin: req=1111 continuously -> grant sequence 0001,0010,0100,1000,0001 every 2 frames.
- Release: owner 2 drops req mid-frame with req=0001 -> grant 0100 until the tick, then 0001; RGB never switches mid-active area.
- Reset mid-frame while owned -> grant=0 the next cycle; frame_start absent until next ivsync rise.
